param_fancy_timer: RTL

PARAM_FANCY_TIMER -- requirements
Module: param_fancy_timer

---
 rtl/param_fancy_timer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/param_fancy_timer.sv
// Serial-triggered delay timer: hunts for PATTERN in the data stream, shifts in a
// DELAY_W-bit delay field, counts (delay+1)*TICKS cycles, then holds done until ack.
module param_fancy_timer #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
    parameter int               DELAY_W = 4,
    parameter int               TICKS   = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               data,
    input  logic               ack,
    input  logic               abort,
    output logic [DELAY_W-1:0] count,
    output logic               counting,
    output logic               done
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam int BIT_W  = (DELAY_W > 1) ? $clog2(DELAY_W) : 1;
    localparam int TICK_W = (TICKS > 1) ? $clog2(TICKS) : 1;

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DELAY_W - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS - 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SHIFT  = 2'd1,
        COUNT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PAT_W-1:0]    hist_q, hist_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DELAY_W-1:0]  delay_q, delay_d;
    logic [DELAY_W-1:0]  count_q, count_d;
    logic [TICK_W-1:0]   tick_q, tick_d;

    logic [PAT_W-1:0]    window_s;
    logic [DELAY_W-1:0]  delay_shift_s;
    logic [FILL_W-1:0]   fill_inc_s;
    logic                match_s;

    // Pattern window includes the bit arriving this cycle so a match is seen on the last pattern bit.
    always_comb begin
        window_s      = (hist_q << 1) | PAT_W'(data);
        delay_shift_s = (delay_q << 1) | DELAY_W'(data);
        if (fill_q == FILL_FULL) begin
            fill_inc_s = FILL_FULL;
        end else begin
            fill_inc_s = fill_q + FILL_W'(1);
        end
        match_s = (fill_inc_s == FILL_FULL) && (window_s == PATTERN);
    end

    // Next-state logic; every register not explicitly held falls back to zero.
    always_comb begin
        state_d = state_q;
        hist_d  = '0;
        fill_d  = '0;
        bit_d   = '0;
        delay_d = '0;
        count_d = '0;
        tick_d  = '0;
        case (state_q)
            SEARCH: begin
                if (match_s) begin
                    state_d = SHIFT;
                end else begin
                    hist_d = window_s;
                    fill_d = fill_inc_s;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = SEARCH;
                end else begin
                    delay_d = delay_shift_s;
                    if (bit_q == BIT_LAST) begin
                        state_d = COUNT;
                        count_d = delay_shift_s;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            COUNT: begin
                if (abort) begin
                    state_d = SEARCH;
                end else if (tick_q == TICK_LAST) begin
                    // Zero is held for one full unit before finishing, giving (delay+1) units.
                    if (count_q != '0) begin
                        count_d = count_q - DELAY_W'(1);
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    tick_d  = tick_q + TICK_W'(1);
                    count_d = count_q;
                end
            end
            DONE: begin
                if (abort || ack) begin
                    state_d = SEARCH;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SEARCH;
            hist_q  <= '0;
            fill_q  <= '0;
            bit_q   <= '0;
            delay_q <= '0;
            count_q <= '0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            bit_q   <= bit_d;
            delay_q <= delay_d;
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign count    = count_q;
    assign counting = (state_q == COUNT);
    assign done     = (state_q == DONE);

endmodule
